// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single memory controller.
// Optional round-robin arbitration is enabled by defining MEM_ARB_RR_EN.
module mem_arbiter #(
  parameter int READ_WAIT  = 2,
  parameter int WR_TIMEOUT = 255
) (
  input  logic        clk50M,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        mem_is_write,
  output logic        mem_opt_is_lw,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  input  logic        mem_busy,
  output logic        err_timeout
);

  typedef enum logic [1:0] {IDLE, RD, WR_PULSE, WR_WAIT} state_t;

  localparam logic [7:0] RD_LAST = 8'(READ_WAIT);
  // WR_WAIT cycles are counted from zero, so the last allowed cycle is one below the limit
  localparam logic [7:0] WR_LAST = 8'(WR_TIMEOUT - 1);

  state_t     state, state_n;
  logic [7:0] cnt;
  logic       win_d;
  logic       start, pick_d, rd_done, wr_done, wr_to;

`ifdef MEM_ARB_RR_EN
  logic last_was_d;
`endif

  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n       = state;
    start         = 1'b0;
    pick_d        = 1'b0;
    rd_done       = 1'b0;
    wr_done       = 1'b0;
    wr_to         = 1'b0;
    mem_is_write  = 1'b0;
    mem_opt_is_lw = 1'b0;
    case (state)
      IDLE: begin
`ifdef MEM_ARB_RR_EN
        pick_d = d_req && (!if_req || !last_was_d);
`else
        pick_d = d_req;
`endif
        if (if_req || d_req) begin
          start   = 1'b1;
          state_n = (pick_d && d_we) ? WR_PULSE : RD;
        end
      end
      RD: begin
        mem_opt_is_lw = 1'b1;
        if (cnt == RD_LAST && !mem_busy) begin
          rd_done = 1'b1;
          state_n = IDLE;
        end
      end
      WR_PULSE: begin
        mem_is_write = 1'b1;
        state_n      = WR_WAIT;
      end
      WR_WAIT: begin
        if (!mem_busy) begin
          wr_done = 1'b1;
          state_n = IDLE;
        end else if (cnt == WR_LAST) begin
          wr_done = 1'b1;
          wr_to   = 1'b1;
          state_n = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      mem_addr    <= '0;
      mem_data_in <= '0;
      win_d       <= 1'b0;
      cnt         <= '0;
      if_ack      <= 1'b0;
      d_ack       <= 1'b0;
      if_rdata    <= '0;
      d_rdata     <= '0;
      err_timeout <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mem_addr    <= pick_d ? d_addr : if_addr;
            mem_data_in <= pick_d ? d_wdata : '0;
            win_d       <= pick_d;
            cnt         <= '0;
          end
        end
        RD: begin
          if (rd_done) begin
            if (win_d) begin
              d_rdata <= mem_data_out;
              d_ack   <= 1'b1;
            end else begin
              if_rdata <= mem_data_out;
              if_ack   <= 1'b1;
            end
          end else if (cnt != RD_LAST) begin
            // counter parks at READ_WAIT while the controller stays busy
            cnt <= cnt + 8'd1;
          end
        end
        WR_PULSE: ;
        WR_WAIT: begin
          if (wr_done) begin
            d_ack <= 1'b1;
            if (wr_to) err_timeout <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
      endcase
    end
  end

`ifdef MEM_ARB_RR_EN
  // reset value "data granted last" gives the fetch port first priority
  always_ff @(posedge clk50M or posedge rst) begin
    if (rst)        last_was_d <= 1'b1;
    else if (start) last_was_d <= pick_d;
  end
`endif

  a_ack_excl: assert property (@(posedge clk50M) disable iff (rst) !(if_ack && d_ack));
  a_wr_pulse: assert property (@(posedge clk50M) disable iff (rst) mem_is_write |=> !mem_is_write);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a driver predicts each completion from
// arbitration/latency rules and a separate monitor checks acks and memory strobes.
module tb_mem_arbiter;
  localparam int RW = 2;
  localparam int TO = 255;

  logic        clk50M = 1'b0, rst = 1'b1;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_busy = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_data_out = '0;
  logic        if_ack, d_ack, mem_is_write, mem_opt_is_lw, err_timeout;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_data_in;

  mem_arbiter #(.READ_WAIT(RW), .WR_TIMEOUT(TO)) dut (
    .clk50M(clk50M), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_is_write(mem_is_write), .mem_opt_is_lw(mem_opt_is_lw),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_busy(mem_busy), .err_timeout(err_timeout)
  );

  always #5 clk50M = ~clk50M;

  int cyc = 0;
  always @(posedge clk50M) cyc <= cyc + 1;

  typedef struct {
    bit          port_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_cyc;
    bit          err;
  } exp_t;

  exp_t sbq[$];
  int   total = 0, bad = 0;
  bit   exp_err = 1'b0;
  bit   last_d = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reads finish once READ_WAIT+1 cycles have elapsed and the controller is idle
  function automatic int rd_lat(input int b);
    return (b + 1 > RW + 1) ? b + 1 : RW + 1;
  endfunction
  // one pulse cycle, then the first idle wait cycle or the timeout limit
  function automatic int wr_lat(input int b);
    int j;
    j = (b < 1) ? 1 : b;
    if (j > TO) j = TO;
    return 1 + j;
  endfunction

  function automatic int lat(input bit we, input int b);
    return we ? wr_lat(b) : rd_lat(b);
  endfunction

  // monitor
  initial begin
    bit prev_wr = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk50M);
      if (rst) begin
        prev_wr = 1'b0;
      end else begin
        if (if_ack && d_ack) check("dual_ack", 32'(1), 32'(0));
        if (mem_is_write) begin
          if (prev_wr) check("wr_pulse_width", 32'(2), 32'(1));
          if (sbq.size() == 0 || !sbq[0].we) check("unexpected_write", 32'(1), 32'(0));
          else begin
            check("wr_addr", mem_addr, sbq[0].addr);
            check("wr_data", mem_data_in, sbq[0].wdata);
          end
        end
        prev_wr = mem_is_write;
        if (mem_opt_is_lw) begin
          if (sbq.size() == 0 || sbq[0].we) check("unexpected_read", 32'(1), 32'(0));
          else check("rd_addr", mem_addr, sbq[0].addr);
        end
        if (if_ack || d_ack) begin
          if (sbq.size() == 0) check("unexpected_ack", 32'(1), 32'(0));
          else begin
            e = sbq.pop_front();
            check("ack_port", 32'(d_ack), 32'(e.port_d));
            check("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
            check("err_timeout", 32'(err_timeout), 32'(e.err));
            if (!e.we) check("rdata", e.port_d ? d_rdata : if_rdata, e.rdata);
          end
        end
      end
    end
  end

  task automatic run_single(input bit port_d, input bit we, input int b,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] data);
    exp_t e;
    int   c0;
    bit   done = 1'b0;
    @(negedge clk50M);
    c0 = cyc + 1;
    e.port_d = port_d; e.we = port_d && we; e.addr = addr; e.wdata = wdata;
    e.rdata = data;
    e.ack_cyc = c0 + lat(e.we, b);
    e.err = exp_err | (e.we && b >= TO + 1);
    exp_err = e.err;
    last_d = port_d;
    sbq.push_back(e);
    if (port_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr; d_we = we;
    end
    mem_data_out = data;
    mem_busy = (b > 0);
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk50M);
      mem_busy = (cyc + 1 - c0) <= b;
      if ((port_d && d_ack) || (!port_d && if_ack)) done = 1'b1;
    end
    if (!done) check("ack_wait_expired", 32'(0), 32'(1));
    if_req = 1'b0; d_req = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic run_pair(input bit dwe);
    exp_t e1, e2;
    int   c0;
    bit   first_d, got_i = 1'b0, got_d = 1'b0;
    logic [31:0] di, dd;
    @(negedge clk50M);
    c0 = cyc + 1;
`ifdef MEM_ARB_RR_EN
    first_d = !last_d;
`else
    first_d = 1'b1;
`endif
    di = $urandom; dd = $urandom;
    if_addr = $urandom; d_addr = $urandom; d_wdata = $urandom; d_we = dwe;
    e1.port_d = first_d;  e1.we = first_d && dwe;
    e2.port_d = !first_d; e2.we = !first_d && dwe;
    e1.addr = first_d ? d_addr : if_addr;  e1.wdata = d_wdata; e1.rdata = first_d ? dd : di;
    e2.addr = first_d ? if_addr : d_addr;  e2.wdata = d_wdata; e2.rdata = first_d ? di : dd;
    e1.ack_cyc = c0 + lat(e1.we, 0);
    e2.ack_cyc = e1.ack_cyc + 1 + lat(e2.we, 0);
    e1.err = exp_err; e2.err = exp_err;
    last_d = e2.port_d;
    sbq.push_back(e1); sbq.push_back(e2);
    mem_data_out = e1.rdata; mem_busy = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    for (int k = 0; k < 400 && !(got_i && got_d); k++) begin
      @(negedge clk50M);
      if (if_ack) begin got_i = 1'b1; if_req = 1'b0; end
      if (d_ack)  begin got_d = 1'b1; d_req = 1'b0; end
      if (got_i || got_d) mem_data_out = e2.rdata;
    end
    if (!(got_i && got_d)) check("pair_wait_expired", 32'(0), 32'(1));
    if_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_lw"},    32'(mem_opt_is_lw), 32'(0));
    check({tag, "_wr"},    32'(mem_is_write),  32'(0));
    check({tag, "_addr"},  mem_addr,           32'(0));
    check({tag, "_din"},   mem_data_in,        32'(0));
    check({tag, "_acks"},  32'({if_ack, d_ack}), 32'(0));
    check({tag, "_irdat"}, if_rdata,           32'(0));
    check({tag, "_drdat"}, d_rdata,            32'(0));
    check({tag, "_err"},   32'(err_timeout),   32'(0));
  endtask

  initial begin
    int b;
    repeat (3) @(negedge clk50M);
    check_reset_outputs("reset");
    rst = 1'b0;

    run_single(1'b0, 1'b0, 0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF);
    run_single(1'b1, 1'b1, 5, 32'h0000_0040, 32'h1234_5678, 32'h0);
    run_single(1'b1, 1'b0, 3, $urandom, $urandom, $urandom);
    run_pair(1'b0);
    run_pair(1'b1);
    run_pair(1'b0);

    for (int i = 0; i < 30; i++) begin
      b = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : 0;
      if ($urandom_range(0, 4) == 0) run_pair(1'($urandom_range(0, 1)));
      else run_single(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), b,
                      $urandom, $urandom, $urandom);
    end

    // stuck-busy write forces a timeout; the flag must stay up afterwards
    run_single(1'b1, 1'b1, 300, $urandom, $urandom, $urandom);
    run_single(1'b0, 1'b0, 0, $urandom, $urandom, $urandom);
    run_single(1'b1, 1'b1, 0, $urandom, $urandom, $urandom);
    repeat (5) @(negedge clk50M);
    check("err_sticky", 32'(err_timeout), 32'(1));

    // reset in the second read cycle
    begin
      exp_t e;
      @(negedge clk50M);
      e.port_d = 1'b0; e.we = 1'b0; e.addr = 32'hCAFE_0010; e.wdata = '0;
      e.rdata = 32'h5555_AAAA; e.ack_cyc = cyc + 1 + rd_lat(0); e.err = exp_err;
      sbq.push_back(e);
      if_req = 1'b1; if_addr = e.addr; mem_data_out = e.rdata;
      @(negedge clk50M);
      @(negedge clk50M);
      check("midread_lw_before", 32'(mem_opt_is_lw), 32'(1));
      #1 rst = 1'b1;
      #1 check_reset_outputs("async_rst");
      sbq.delete();
      exp_err = 1'b0; last_d = 1'b1;
      if_req = 1'b0;
      repeat (4) begin
        @(negedge clk50M);
        check("ack_during_rst", 32'({if_ack, d_ack}), 32'(0));
      end
      rst = 1'b0;
      repeat (4) begin
        @(negedge clk50M);
        check("no_ack_after_abort", 32'({if_ack, d_ack}), 32'(0));
      end
    end
    run_single(1'b0, 1'b0, 0, $urandom, $urandom, $urandom);
    run_pair(1'b0);

    repeat (5) @(negedge clk50M);
    check("scoreboard_empty", 32'(sbq.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
